wsa_join: RTL and testbench
===========================

Name: wsa_join

Overview:
- Receiving end of the three-channel wsa result interface.
- Consumes the OR, AND and XOR result streams independently on ready/valid channels. Each stream may arrive skewed in time.
- Joins one token from each stream, checks their bitwise consistency, reconstructs the arithmetic sum of the original operand pair (a+b = xor + 2·and), and emits it on one registered ready/valid output.
- Sits downstream of the wsa fork stage in the datapath.

Parameters:
- WIDTH, 32, operand/result-stream data width.
- CNT_W, 16, error-counter width (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- or_data  input  WIDTH  OR stream data
- or_vld  input  1  OR stream valid
- or_rdy  output  1  OR stream ready
- and_data  input  WIDTH  AND stream data
- and_vld  input  1  AND stream valid
- and_rdy  output  1  AND stream ready
- xor_data  input  WIDTH  XOR stream data
- xor_vld  input  1  XOR stream valid
- xor_rdy  output  1  XOR stream ready
- sum_data  output  WIDTH+1  reconstructed a+b
- sum_err  output  1  consistency error flag, travels with sum_data
- sum_vld  output  1  output valid
- sum_rdy  input  1  output ready
- err_cnt  output  CNT_W  saturating error count (only with WSA_JOIN_ERRCNT_EN)

Behaviour:
- Each input channel has a one-entry hold register with a data field and a hold_vld flag.
- join_fire = or_hold_vld & and_hold_vld & xor_hold_vld & (~sum_vld | sum_rdy).
- Ready per input: x_rdy = ~x_hold_vld | join_fire. There is a combinational path from sum_rdy to x_rdy; this is intended.
- Transfer on an input: x_vld & x_rdy loads the hold register and sets x_hold_vld.
- Hold flag update on join_fire: x_hold_vld clears, unless the same cycle also transfers on that input, in which case it stays set with the new data.
- The three inputs are fully independent:
  - a channel may deliver its token before, with or after the others;
  - a held token blocks only its own channel;
  - tokens are never dropped or reordered.
- Output register update on join_fire:
  - sum_data <= zext(xor_hold) + (zext(and_hold) << 1), computed at WIDTH+1 bits with no overflow;
  - sum_err <= ((or_hold & ~and_hold) != xor_hold) | ((and_hold & ~or_hold) != 0);
  - sum_vld <= 1.
- Output hold and clear: if sum_vld & sum_rdy & ~join_fire, sum_vld <= 0. While sum_vld & ~sum_rdy, sum_data, sum_err and sum_vld hold stable.
- Latency: all three tokens transferred in cycle N with the output free gives sum_vld in cycle N+2 (hold in N+1, fire in N+1, output register in N+2).
- Throughput: one result per cycle sustained when all inputs are valid and sum_rdy=1.
- Reset values: all hold_vld=0, hold data=0, sum_vld=0, sum_data=0, sum_err=0, err_cnt=0. Consequently or_rdy, and_rdy and xor_rdy are 1 out of reset.
- Reset mid-operation: all partially joined tokens and any pending output are discarded; nothing is emitted after reset deasserts until new tokens arrive.
- sum_err does not stall or drop data; an erroneous result is still emitted.

Optional Feature:
- Macro: WSA_JOIN_ERRCNT_EN.
- Defined:
  - err_cnt port exists;
  - increments by 1 on each output transfer (sum_vld & sum_rdy) with sum_err=1;
  - saturates at 2^CNT_W-1;
  - cleared only by rst.
- Undefined: err_cnt port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package wsa_pkg:
  - WSA_WIDTH constant (32);
  - typedef wsa_word_t (WIDTH bits);
  - typedef wsa_sum_t (WIDTH+1 bits);
  - function wsa_consistent(or, and, xor) returning the error predicate.
- One sub-module is natural: wsa_hold_slot (one-entry hold register with vld/rdy and a release input), instantiated three times.

Test Plan:
- Aligned inputs: or=0x000000FF, and=0x000000F0, xor=0x0000000F presented together in cycle N, sum_rdy=1 -> sum_vld=1 in cycle N+2 with sum_data=0x1EF, sum_err=0.
- Max operands: or=and=0xFFFFFFFF, xor=0x0 -> sum_data=0x1_FFFFFFFE, sum_err=0.
- Skewed arrival: xor at cycle 0, or at cycle 3, and at cycle 7 -> xor_rdy=0 during cycles 1-7, or_rdy=0 during cycles 4-7, sum_vld rises in cycle 9, single result emitted.
- Inconsistent token: or=0x0, and=0x1, xor=0x0 -> sum_data=0x2, sum_err=1; with WSA_JOIN_ERRCNT_EN, err_cnt reads 1 after the transfer.
- Backpressure: 4 back-to-back aligned tokens with sum_rdy=0 for 5 cycles, then 1 -> output holds token 0 stable, inputs stall after the second token, all 4 sums emitted in order with no loss.
- Mid-stream reset: hold or and and tokens, assert rst for 1 cycle, then send only xor -> sum_vld stays 0 and or_rdy=and_rdy=1 after reset.

Source files
------------

// File: rtl/wsa_pkg.sv
// Shared types and helpers for the wsa fork/join datapath.
package wsa_pkg;
  localparam int WSA_WIDTH = 32;

  typedef logic [WSA_WIDTH-1:0] wsa_word_t;
  typedef logic [WSA_WIDTH:0]   wsa_sum_t;

  // Returns 1 when the or/and/xor triple could not come from one operand pair.
  function automatic logic wsa_consistent(wsa_word_t o, wsa_word_t a, wsa_word_t x);
    return ((o & ~a) != x) | ((a & ~o) != '0);
  endfunction
endpackage

// File: rtl/wsa_join_if.sv
// Three-channel wsa result bus plus the joined sum output.
interface wsa_join_if #(parameter int WIDTH = wsa_pkg::WSA_WIDTH);
  logic [WIDTH-1:0] or_data;
  logic             or_vld;
  logic             or_rdy;
  logic [WIDTH-1:0] and_data;
  logic             and_vld;
  logic             and_rdy;
  logic [WIDTH-1:0] xor_data;
  logic             xor_vld;
  logic             xor_rdy;
  logic [WIDTH:0]   sum_data;
  logic             sum_err;
  logic             sum_vld;
  logic             sum_rdy;

  modport master (
    output or_data, or_vld, and_data, and_vld, xor_data, xor_vld, sum_rdy,
    input  or_rdy, and_rdy, xor_rdy, sum_data, sum_err, sum_vld
  );

  modport slave (
    input  or_data, or_vld, and_data, and_vld, xor_data, xor_vld, sum_rdy,
    output or_rdy, and_rdy, xor_rdy, sum_data, sum_err, sum_vld
  );
endinterface

// File: rtl/wsa_hold_slot.sv
// One-entry hold register; accepts a new token in the same cycle it is released.
module wsa_hold_slot import wsa_pkg::*; #(
  parameter int WIDTH = WSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             vld_i,
  output logic             rdy_o,
  input  logic             rel_i,
  output logic [WIDTH-1:0] data_o,
  output logic             vld_o
);
  logic [WIDTH-1:0] data_q;
  logic             vld_q;

  assign rdy_o  = ~vld_q | rel_i;
  assign data_o = data_q;
  assign vld_o  = vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (vld_i & rdy_o) begin
      data_q <= data_i;
      vld_q  <= 1'b1;
    end else if (rel_i) begin
      vld_q  <= 1'b0;
    end
  end
endmodule

// File: rtl/wsa_join.sv
// Joins or/and/xor streams into a+b with a consistency flag.
// Optional saturating error counter: define WSA_JOIN_ERRCNT_EN.
module wsa_join import wsa_pkg::*; #(
  parameter int WIDTH = WSA_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  wsa_join_if.slave        bus
`ifdef WSA_JOIN_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);
  logic [WIDTH-1:0] or_h, and_h, xor_h;
  logic             or_hv, and_hv, xor_hv;
  logic             join_fire;

  logic [WIDTH:0]   sum_data_q, sum_data_d;
  logic             sum_err_q, sum_err_d;
  logic             sum_vld_q, sum_vld_d;

  // Output slot frees up either when empty or when drained this cycle.
  assign join_fire = or_hv & and_hv & xor_hv & (~sum_vld_q | bus.sum_rdy);

  wsa_hold_slot #(.WIDTH(WIDTH)) u_or (
    .clk, .rst, .data_i(bus.or_data), .vld_i(bus.or_vld), .rdy_o(bus.or_rdy),
    .rel_i(join_fire), .data_o(or_h), .vld_o(or_hv)
  );
  wsa_hold_slot #(.WIDTH(WIDTH)) u_and (
    .clk, .rst, .data_i(bus.and_data), .vld_i(bus.and_vld), .rdy_o(bus.and_rdy),
    .rel_i(join_fire), .data_o(and_h), .vld_o(and_hv)
  );
  wsa_hold_slot #(.WIDTH(WIDTH)) u_xor (
    .clk, .rst, .data_i(bus.xor_data), .vld_i(bus.xor_vld), .rdy_o(bus.xor_rdy),
    .rel_i(join_fire), .data_o(xor_h), .vld_o(xor_hv)
  );

  always_comb begin
    sum_data_d = sum_data_q;
    sum_err_d  = sum_err_q;
    sum_vld_d  = sum_vld_q;
    if (join_fire) begin
      // a+b = (a^b) + 2(a&b); the extra bit absorbs the carry out.
      sum_data_d = {1'b0, xor_h} + {and_h, 1'b0};
      sum_err_d  = ((or_h & ~and_h) != xor_h) | ((and_h & ~or_h) != '0);
      sum_vld_d  = 1'b1;
    end else if (sum_vld_q & bus.sum_rdy) begin
      sum_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_data_q <= '0;
      sum_err_q  <= 1'b0;
      sum_vld_q  <= 1'b0;
    end else begin
      sum_data_q <= sum_data_d;
      sum_err_q  <= sum_err_d;
      sum_vld_q  <= sum_vld_d;
    end
  end

  assign bus.sum_data = sum_data_q;
  assign bus.sum_err  = sum_err_q;
  assign bus.sum_vld  = sum_vld_q;

`ifdef WSA_JOIN_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (sum_vld_q & bus.sum_rdy & sum_err_q & ~(&err_cnt_q))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_wsa_join.sv
// Bench for wsa_join: directed scenarios plus randomized skew/backpressure vs an a+b model.
module tb_wsa_join;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wsa_join_if #(.WIDTH(W)) bus();

`ifdef WSA_JOIN_ERRCNT_EN
  logic [15:0] err_cnt;
  wsa_join #(.WIDTH(W), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus), .err_cnt(err_cnt));
`else
  wsa_join #(.WIDTH(W), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct {
    logic [W-1:0] o, n, x;
    logic [W:0]   s;
    logic         e;
  } tok_t;

  tok_t         toks[$];
  int           ptr[3];
  int           n_out;
  logic [W-1:0] din[3];
  logic         vin[3];
  bit           en[3];
  logic [2:0]   r_rdy;
  logic         r_svld;
  int           errs;
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model works from the operands themselves: the sum is plain a+b.
  task automatic push_ab(logic [W-1:0] a, logic [W-1:0] b);
    tok_t t;
    t.o = a | b; t.n = a & b; t.x = a ^ b;
    t.s = {1'b0, a} + {1'b0, b};
    t.e = 1'b0;
    toks.push_back(t);
  endtask

  task automatic push_raw(logic [W-1:0] o, logic [W-1:0] n, logic [W-1:0] x);
    tok_t t;
    t.o = o; t.n = n; t.x = x;
    t.s = {1'b0, x} + 2 * {1'b0, n};
    t.e = ((o & ~n) != x) || ((n & ~o) != 0);
    toks.push_back(t);
  endtask

  function automatic logic [W-1:0] field(tok_t t, int c);
    return (c == 0) ? t.o : (c == 1) ? t.n : t.x;
  endfunction

  task automatic drive();
    bus.or_data  = din[0]; bus.or_vld  = vin[0];
    bus.and_data = din[1]; bus.and_vld = vin[1];
    bus.xor_data = din[2]; bus.xor_vld = vin[2];
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic run_cycle(int gap_pct, bit srdy);
    bit hs[3];
    bus.sum_rdy = srdy;
    for (int c = 0; c < 3; c++) begin
      hs[c] = 1'b0;
      if (!vin[c] && en[c] && ptr[c] < toks.size() && $urandom_range(0, 99) >= gap_pct) begin
        vin[c] = 1'b1;
        din[c] = field(toks[ptr[c]], c);
      end
    end
    drive();
    #1;
    r_rdy  = {bus.xor_rdy, bus.and_rdy, bus.or_rdy};
    r_svld = bus.sum_vld;
    if (bus.sum_vld) begin
      if (n_out >= toks.size()) chk("spurious_vld", {63'd0, bus.sum_vld}, 64'd0);
      else begin
        chk("sum_data", {31'd0, bus.sum_data}, {31'd0, toks[n_out].s});
        chk("sum_err", {63'd0, bus.sum_err}, {63'd0, toks[n_out].e});
        if (srdy) begin
          if (toks[n_out].e && errs < 65535) errs++;
          n_out++;
        end
      end
    end
    for (int c = 0; c < 3; c++)
      if (vin[c] && r_rdy[c]) begin ptr[c]++; hs[c] = 1'b1; end
    @(negedge clk);
    for (int c = 0; c < 3; c++) if (hs[c]) vin[c] = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin vin[c] = 1'b0; ptr[c] = toks.size(); en[c] = 1'b1; end
    n_out = toks.size();
    errs  = 0;
    drive();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rdy", {61'd0, bus.xor_rdy, bus.and_rdy, bus.or_rdy}, 64'h7);
    chk("rst_vld", {63'd0, bus.sum_vld}, 64'd0);
  endtask

  initial begin
    int base;
    for (int c = 0; c < 3; c++) begin din[c] = '0; vin[c] = 1'b0; en[c] = 1'b1; ptr[c] = 0; end
    n_out = 0; errs = 0;
    bus.sum_rdy = 1'b1;
    drive();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_rdy", {61'd0, bus.xor_rdy, bus.and_rdy, bus.or_rdy}, 64'h7);
    chk("reset_vld", {63'd0, bus.sum_vld}, 64'd0);
    chk("reset_data", {31'd0, bus.sum_data}, 64'd0);
    chk("reset_err", {63'd0, bus.sum_err}, 64'd0);
`ifdef WSA_JOIN_ERRCNT_EN
    chk("reset_errcnt", {48'd0, err_cnt}, 64'd0);
`endif
    @(negedge clk);

    // Aligned tokens: result two cycles after the transfer.
    push_raw(32'h000000FF, 32'h000000F0, 32'h0000000F);
    for (int k = 0; k < 5; k++) begin
      run_cycle(0, 1'b1);
      chk($sformatf("aligned_vld_c%0d", k), {63'd0, r_svld}, {63'd0, k == 2});
      if (k == 2) begin
        chk("aligned_data", {31'd0, bus.sum_data}, 64'h1EF);
        chk("aligned_err", {63'd0, bus.sum_err}, 64'd0);
      end
    end

    // Largest operands carry into the top bit.
    push_raw(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    for (int k = 0; k < 4; k++) begin
      run_cycle(0, 1'b1);
      if (k == 2) chk("max_data", {31'd0, bus.sum_data}, 64'h1_FFFFFFFE);
    end

    // Skewed arrival: xor@0, or@3, and@7.
    push_ab(32'h12345678, 32'h0F0F0F0F);
    base = n_out;
    for (int k = 0; k < 12; k++) begin
      en[2] = 1'b1; en[0] = (k >= 3); en[1] = (k >= 7);
      run_cycle(0, 1'b1);
      if (k >= 1 && k <= 7) chk($sformatf("skew_xor_rdy_c%0d", k), {63'd0, r_rdy[2]}, 64'd0);
      if (k >= 4 && k <= 7) chk($sformatf("skew_or_rdy_c%0d", k), {63'd0, r_rdy[0]}, 64'd0);
      chk($sformatf("skew_vld_c%0d", k), {63'd0, r_svld}, {63'd0, k == 9});
    end
    chk("skew_count", n_out - base, 1);

    // Inconsistent token is still emitted, flagged.
    do_reset();
    push_raw(32'h0, 32'h1, 32'h0);
    for (int k = 0; k < 4; k++) begin
      run_cycle(0, 1'b1);
      if (k == 2) begin
        chk("bad_data", {31'd0, bus.sum_data}, 64'h2);
        chk("bad_err", {63'd0, bus.sum_err}, 64'd1);
      end
    end
`ifdef WSA_JOIN_ERRCNT_EN
    chk("bad_errcnt", {48'd0, err_cnt}, 64'd1);
`endif

    // Backpressure: 4 tokens, sum_rdy low for 5 cycles.
    base = ptr[0];
    for (int i = 0; i < 4; i++) push_ab($urandom, $urandom);
    for (int k = 0; k < 14; k++) begin
      run_cycle(0, k >= 5);
      if (k >= 2 && k <= 4) chk($sformatf("bp_hold_vld_c%0d", k), {63'd0, r_svld}, 64'd1);
      if (k == 4) chk("bp_stall_tokens", ptr[0] - base, 2);
    end
    chk("bp_all_out", n_out, toks.size());

    // Mid-stream reset drops partially joined tokens.
    push_ab(32'hAAAA5555, 32'h0000FFFF);
    en[2] = 1'b0;
    run_cycle(0, 1'b1);
    run_cycle(0, 1'b1);
    do_reset();
    push_ab(32'h1, 32'h2);
    en[0] = 1'b0; en[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      run_cycle(0, 1'b1);
      chk($sformatf("mrst_vld_c%0d", k), {63'd0, r_svld}, 64'd0);
      chk($sformatf("mrst_orand_rdy_c%0d", k), {62'd0, r_rdy[1:0]}, 64'h3);
    end

    // Random skew and backpressure against the model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) push_raw($urandom, $urandom, $urandom);
      else if ($urandom_range(0, 7) == 0) push_ab(32'hFFFFFFFF, $urandom);
      else push_ab($urandom, $urandom);
    end
    for (int k = 0; k < 5000 && n_out < toks.size(); k++)
      run_cycle(40, $urandom_range(0, 3) != 0);
    chk("rand_all_out", n_out, toks.size());
`ifdef WSA_JOIN_ERRCNT_EN
    chk("rand_errcnt", {48'd0, err_cnt}, errs);
`endif
    for (int k = 0; k < 4; k++) run_cycle(0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
